// File: rtl/combat_pkg.sv
// Shared types and constants for the two-fighter combat arbiter.
// Contents: FSM state enum, attack-kind enum, default damage values,
//   counter/health widths and the dmg_of() damage helper.
package combat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIGHT,
    RESOLVE,
    KO
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    PUNCH,
    KICK
  } atk_e;

  localparam int DEF_PUNCH_DMG   = 5;
  localparam int DEF_KICK_DMG    = 10;
  localparam int DEF_BLOCK_SHIFT = 2;
  localparam int HP_W            = 8;
  localparam int CNT_W           = 8;

  // Damage dealt by one attack; a blocked attack is reduced by a right shift.
  // The trailing arguments let a parameterised instance override the defaults.
  function automatic logic [HP_W-1:0] dmg_of(
    input atk_e kind,
    input logic blocked,
    input int   punch_dmg   = DEF_PUNCH_DMG,
    input int   kick_dmg    = DEF_KICK_DMG,
    input int   block_shift = DEF_BLOCK_SHIFT
  );
    logic [HP_W-1:0] raw;
    case (kind)
      PUNCH:   raw = HP_W'(punch_dmg);
      KICK:    raw = HP_W'(kick_dmg);
      default: raw = '0;
    endcase
    return blocked ? (raw >> block_shift) : raw;
  endfunction

endpackage

// File: rtl/fighter_timer.sv
// Per-fighter attack cooldown and hit-stun counters.
// Latency: counters step on the RESOLVE cycle; o_ready is combinational from the
//   already-decremented values so a counter expiring this frame allows a launch.
// Ports: i_clk/i_rst_n, i_clr (hold at zero), i_step (one frame step), i_launch
//   (reload cooldown), i_stun_hit (reload stun), o_ready, o_stun.
module fighter_timer
  import combat_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 20,
  parameter int STUN_FRAMES     = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_step,
  input  logic i_launch,
  input  logic i_stun_hit,
  output logic o_ready,
  output logic o_stun
);

  logic [CNT_W-1:0] r_cd;
  logic [CNT_W-1:0] r_stun;
  logic [CNT_W-1:0] w_cd_dec;
  logic [CNT_W-1:0] w_stun_dec;

  assign w_cd_dec   = (r_cd   != '0) ? r_cd   - CNT_W'(1) : '0;
  assign w_stun_dec = (r_stun != '0) ? r_stun - CNT_W'(1) : '0;
  assign o_ready    = (w_cd_dec == '0) && (w_stun_dec == '0);
  assign o_stun     = (r_stun != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cd   <= '0;
      r_stun <= '0;
    end else if (i_clr) begin
      r_cd   <= '0;
      r_stun <= '0;
    end else if (i_step) begin
      r_cd   <= i_launch   ? CNT_W'(COOLDOWN_FRAMES) : w_cd_dec;
      r_stun <= i_stun_hit ? CNT_W'(STUN_FRAMES)     : w_stun_dec;
    end
  end

endmodule

// File: rtl/combat_arbiter.sv
// Per-frame hit resolution: launch/range/damage/KO for the two fighters.
// Latency: vsync rise -> tick after 3 Clk -> RESOLVE -> outputs update 5 Clk after vsync.
// Ports: Clk, reset_rtl_0 (async low), vsync, fighting, per-fighter action flags and
//   facing edges in; health, death, stun and hit_pulse out.
module combat_arbiter
  import combat_pkg::*;
#(
  parameter int HEALTH_MAX      = 100,
  parameter int PUNCH_DMG       = DEF_PUNCH_DMG,
  parameter int KICK_DMG        = DEF_KICK_DMG,
  parameter int BLOCK_SHIFT     = DEF_BLOCK_SHIFT,
  parameter int REACH           = 16,
  parameter int COOLDOWN_FRAMES = 20,
  parameter int STUN_FRAMES     = 12
) (
  input  logic            Clk,
  input  logic            reset_rtl_0,
  input  logic            vsync,
  input  logic            fighting,
  input  logic            punchL,
  input  logic            kickL,
  input  logic            blockL,
  input  logic            punchR,
  input  logic            kickR,
  input  logic            blockR,
  input  logic [9:0]      edgeL_R,
  input  logic [9:0]      edgeR_L,
  output logic [HP_W-1:0] healthL,
  output logic [HP_W-1:0] healthR,
  output logic            deathL,
  output logic            deathR,
  output logic            stunL,
  output logic            stunR,
  output logic [1:0]      hit_pulse
);

  // vsync synchroniser and registered rising-edge tick
  logic r_vs_meta, r_vs_sync, r_vs_prev, r_tick;

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vs_meta <= vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_tick    <= r_vs_sync & ~r_vs_prev;
    end
  end

  state_e r_state, w_next;
  logic [HP_W-1:0] r_hpL, r_hpR, w_hpL_nxt, w_hpR_nxt, w_dmgL, w_dmgR;
  logic r_deathL, r_deathR, r_prevL, r_prevR;
  logic [1:0] r_hit;
  logic w_commit, w_clr;
  logic w_riseL, w_riseR, w_readyL, w_readyR, w_launchL, w_launchR, w_hitL, w_hitR;
  logic w_in_range;
  logic signed [10:0] w_gap;
  atk_e w_kindL, w_kindR;

  // Dropping 'fighting' mid-RESOLVE aborts the commit along with the return to IDLE.
  assign w_commit = (r_state == RESOLVE) && fighting;
  assign w_clr    = (r_state == IDLE);

  assign w_kindL = kickL ? KICK : (punchL ? PUNCH : NONE);
  assign w_kindR = kickR ? KICK : (punchR ? PUNCH : NONE);
  assign w_riseL = (punchL | kickL) & ~r_prevL;
  assign w_riseR = (punchR | kickR) & ~r_prevR;

  // Unsigned edges widened by a zero MSB so overlap yields a negative gap.
  assign w_gap      = $signed({1'b0, edgeR_L}) - $signed({1'b0, edgeL_R});
  assign w_in_range = (w_gap <= $signed(11'(REACH)));

  assign w_launchL = w_commit & w_riseL & w_readyL;
  assign w_launchR = w_commit & w_riseR & w_readyR;
  assign w_hitL    = w_launchL & w_in_range;
  assign w_hitR    = w_launchR & w_in_range;

  // Both sides resolve against pre-RESOLVE health, so simultaneous hits trade.
  assign w_dmgR    = w_hitL ? dmg_of(w_kindL, blockR, PUNCH_DMG, KICK_DMG, BLOCK_SHIFT) : '0;
  assign w_dmgL    = w_hitR ? dmg_of(w_kindR, blockL, PUNCH_DMG, KICK_DMG, BLOCK_SHIFT) : '0;
  assign w_hpL_nxt = (r_hpL > w_dmgL) ? r_hpL - w_dmgL : '0;
  assign w_hpR_nxt = (r_hpR > w_dmgR) ? r_hpR - w_dmgR : '0;

  fighter_timer #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES), .STUN_FRAMES(STUN_FRAMES)) u_timer_l (
    .i_clk(Clk), .i_rst_n(reset_rtl_0), .i_clr(w_clr), .i_step(w_commit),
    .i_launch(w_launchL), .i_stun_hit(w_hitR & ~blockL),
    .o_ready(w_readyL), .o_stun(stunL)
  );

  fighter_timer #(.COOLDOWN_FRAMES(COOLDOWN_FRAMES), .STUN_FRAMES(STUN_FRAMES)) u_timer_r (
    .i_clk(Clk), .i_rst_n(reset_rtl_0), .i_clr(w_clr), .i_step(w_commit),
    .i_launch(w_launchR), .i_stun_hit(w_hitL & ~blockR),
    .o_ready(w_readyR), .o_stun(stunR)
  );

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) r_state <= IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (fighting) w_next = FIGHT;
      FIGHT:   if (r_tick) w_next = RESOLVE;
      RESOLVE: w_next = ((w_hpL_nxt == '0) || (w_hpR_nxt == '0)) ? KO : FIGHT;
      KO:      w_next = KO;
      default: w_next = IDLE;
    endcase
    if (!fighting) w_next = IDLE;
  end

  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      r_hpL    <= HP_W'(HEALTH_MAX);
      r_hpR    <= HP_W'(HEALTH_MAX);
      r_deathL <= 1'b0;
      r_deathR <= 1'b0;
      r_prevL  <= 1'b0;
      r_prevR  <= 1'b0;
      r_hit    <= 2'b00;
    end else begin
      r_hit <= 2'b00;
      if (r_state == IDLE) begin
        r_hpL    <= HP_W'(HEALTH_MAX);
        r_hpR    <= HP_W'(HEALTH_MAX);
        r_deathL <= 1'b0;
        r_deathR <= 1'b0;
      end else if (w_commit) begin
        r_hpL    <= w_hpL_nxt;
        r_hpR    <= w_hpR_nxt;
        r_deathL <= r_deathL | (w_hpL_nxt == '0);
        r_deathR <= r_deathR | (w_hpR_nxt == '0);
        r_hit    <= {w_hitR, w_hitL};
        r_prevL  <= punchL | kickL;
        r_prevR  <= punchR | kickR;
      end
    end
  end

  assign healthL   = r_hpL;
  assign healthR   = r_hpR;
  assign deathL    = r_deathL;
  assign deathR    = r_deathR;
  assign hit_pulse = r_hit;

endmodule

// File: tb/tb_combat_arbiter.sv
module tb_combat_arbiter;

  localparam logic [5:0] A_PL = 6'b100000, A_KL = 6'b010000, A_BL = 6'b001000;
  localparam logic [5:0] A_PR = 6'b000100, A_KR = 6'b000010, A_BR = 6'b000001;
  localparam int STUN = 12;

  logic Clk = 1'b0;
  logic reset_rtl_0, vsync, fighting;
  logic punchL, kickL, blockL, punchR, kickR, blockR;
  logic [9:0] edgeL_R, edgeR_L;
  logic [7:0] healthL, healthR;
  logic deathL, deathR, stunL, stunR;
  logic [1:0] hit_pulse;

  always #5 Clk = ~Clk;

  combat_arbiter dut (
    .Clk(Clk), .reset_rtl_0(reset_rtl_0), .vsync(vsync), .fighting(fighting),
    .punchL(punchL), .kickL(kickL), .blockL(blockL),
    .punchR(punchR), .kickR(kickR), .blockR(blockR),
    .edgeL_R(edgeL_R), .edgeR_L(edgeR_L),
    .healthL(healthL), .healthR(healthR), .deathL(deathL), .deathR(deathR),
    .stunL(stunL), .stunR(stunR), .hit_pulse(hit_pulse)
  );

  typedef struct packed {
    logic [15:0] tag;
    logic [7:0]  hpL;
    logic [7:0]  hpR;
    logic        dL, dR, sL, sR;
    logic [1:0]  hit;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int frame_no = 0;
  bit mon_en = 1'b0;

  // Expected state carried between directed frames.
  int e_hpL = 100, e_hpR = 100, e_stL = 0, e_stR = 0;
  bit e_ko = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_act(input logic [5:0] a, input int gap);
    {punchL, kickL, blockL, punchR, kickR, blockR} = a;
    edgeL_R = 10'd300;
    edgeR_L = 10'(300 + gap);
  endtask

  // One video frame: hand-computed health after this frame's RESOLVE, the
  // expected hit_pulse, and whether each side gets a fresh stun load.
  task automatic frame(input logic [5:0] a, input int gap, input logic [1:0] hit,
                       input int hpL, input int hpR, input bit ldL, input bit ldR);
    exp_t x;
    if (!e_ko) begin
      if (e_stL > 0) e_stL--;
      if (e_stR > 0) e_stR--;
      if (ldL) e_stL = STUN;
      if (ldR) e_stR = STUN;
      e_hpL = hpL;
      e_hpR = hpR;
    end
    x.tag = 16'(frame_no);
    x.hpL = 8'(e_hpL);
    x.hpR = 8'(e_hpR);
    x.dL  = (e_hpL == 0);
    x.dR  = (e_hpR == 0);
    x.sL  = (e_stL != 0);
    x.sR  = (e_stR != 0);
    x.hit = hit;
    if (e_hpL == 0 || e_hpR == 0) e_ko = 1'b1;
    frame_no++;
    @(negedge Clk);
    set_act(a, gap);
    sb.push_back(x);
    vsync = 1'b1;
    repeat (8) @(negedge Clk);
    vsync = 1'b0;
    repeat (8) @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(6'b0, 100, 2'b00, e_hpL, e_hpR, 1'b0, 1'b0);
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, " healthL"}, healthL, 100);
    chk({pfx, " healthR"}, healthR, 100);
    chk({pfx, " deathL"}, deathL, 0);
    chk({pfx, " deathR"}, deathR, 0);
    chk({pfx, " stunL"}, stunL, 0);
    chk({pfx, " stunR"}, stunR, 0);
    chk({pfx, " hit_pulse"}, hit_pulse, 0);
  endtask

  // Monitor: outputs for a frame are valid 5 Clk after vsync rises; hit_pulse
  // must drop again one cycle later.
  initial begin
    exp_t x;
    forever begin
      @(posedge vsync);
      if (mon_en) begin
        repeat (5) @(posedge Clk);
        #1;
        chk("scoreboard has entry", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          x = sb.pop_front();
          chk($sformatf("f%0d healthL", x.tag), healthL, x.hpL);
          chk($sformatf("f%0d healthR", x.tag), healthR, x.hpR);
          chk($sformatf("f%0d deathL", x.tag), deathL, x.dL);
          chk($sformatf("f%0d deathR", x.tag), deathR, x.dR);
          chk($sformatf("f%0d stunL", x.tag), stunL, x.sL);
          chk($sformatf("f%0d stunR", x.tag), stunR, x.sR);
          chk($sformatf("f%0d hit_pulse", x.tag), hit_pulse, x.hit);
          @(posedge Clk);
          #1;
          chk($sformatf("f%0d hit_pulse cleared", x.tag), hit_pulse, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_rtl_0 = 1'b0;
    vsync = 1'b0;
    fighting = 1'b0;
    set_act(6'b0, 100);
    repeat (3) @(negedge Clk);
    chk_idle_outputs("reset");
    reset_rtl_0 = 1'b1;
    @(negedge Clk);
    fighting = 1'b1;
    repeat (3) @(negedge Clk);
    mon_en = 1'b1;

    // Quiet fight: nothing changes without attack edges.
    idle(10);

    // Left kick lands unblocked, right stunned for 12 frames.
    frame(A_KL, 10, 2'b01, 100, 90, 1'b0, 1'b1);       // f0
    idle(4);
    frame(A_PR, 10, 2'b00, 100, 90, 1'b0, 1'b0);       // f5: stunned, ignored
    idle(6);
    frame(A_PR | A_BL, 10, 2'b10, 99, 90, 1'b0, 1'b0); // f12: stun expires, blocked punch 5>>2
    idle(5);
    frame(A_KL, 10, 2'b00, 99, 90, 1'b0, 1'b0);        // f18: cooldown
    idle(1);
    frame(A_KL | A_BR, 10, 2'b01, 99, 88, 1'b0, 1'b0); // f20: blocked kick 10>>2
    idle(4);
    frame(A_KL | A_BR, 10, 2'b00, 99, 88, 1'b0, 1'b0); // f25: cooldown
    idle(14);
    frame(A_KL | A_BR, 16, 2'b01, 99, 86, 1'b0, 1'b0); // f40: gap == REACH
    idle(19);

    // Trade at gap 0, then a miss at gap 17 that still loads both cooldowns.
    frame(A_PL | A_PR, 0, 2'b11, 94, 81, 1'b1, 1'b1);  // f60
    idle(19);
    frame(A_PL | A_PR, 17, 2'b00, 94, 81, 1'b0, 1'b0); // f80
    idle(1);
    frame(A_PL | A_PR, 0, 2'b00, 94, 81, 1'b0, 1'b0);  // f82: both cooling down

    // Asynchronous reset asserted while the FSM sits in RESOLVE.
    mon_en = 1'b0;
    @(negedge Clk);
    set_act(A_KL | A_KR, 0);
    vsync = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    reset_rtl_0 = 1'b0;
    #1;
    chk_idle_outputs("reset in RESOLVE");
    @(negedge Clk);
    vsync = 1'b0;
    set_act(6'b0, 100);
    repeat (3) @(negedge Clk);
    reset_rtl_0 = 1'b1;
    repeat (4) @(negedge Clk);
    e_hpL = 100; e_hpR = 100; e_stL = 0; e_stR = 0; e_ko = 1'b0;
    mon_en = 1'b1;

    // Overlapping fighters trade kicks down to 10/10, punches to 5/5, then a draw.
    for (int i = 1; i <= 9; i++) begin
      frame(A_KL | A_KR, -8, 2'b11, 100 - 10 * i, 100 - 10 * i, 1'b1, 1'b1);
      idle(19);
    end
    frame(A_PL | A_PR, -8, 2'b11, 5, 5, 1'b1, 1'b1);
    idle(19);
    frame(A_PL | A_PR, -8, 2'b11, 0, 0, 1'b1, 1'b1);

    // KO: outputs frozen whatever the fighters do.
    idle(1);
    frame(A_KL | A_KR, 0, 2'b00, 0, 0, 1'b0, 1'b0);
    idle(1);
    frame(A_PL | A_PR, 0, 2'b00, 0, 0, 1'b0, 1'b0);

    // Leaving the fight screen restores full health and clears everything.
    set_act(6'b0, 100);
    fighting = 1'b0;
    repeat (2) @(negedge Clk);
    chk_idle_outputs("back to IDLE");
    chk("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/combat_arbiter.md
# combat_arbiter

- Per-frame hit resolution for the two-fighter game: samples both fighters' punch/kick/block flags and body edges once per video frame.
- Decides which attacks land (simultaneous hits trade), applies damage with block reduction, and enforces per-fighter attack cooldown and hit-stun.
- Owns `healthL`/`healthR` and `deathL`/`deathR`, which it drives to the color mapper and the `states` sequencer.
- Sits between the two fighter motion modules and `states`, clocked on the 25 MHz pixel clock.

## Interface
Parameters:
- `HEALTH_MAX`, 100 — health loaded at fight start; must be ≤ 255.
- `PUNCH_DMG`, 5 — punch damage.
- `KICK_DMG`, 10 — kick damage.
- `BLOCK_SHIFT`, 2 — blocked damage = dmg >> BLOCK_SHIFT.
- `REACH`, 16 — max gap in pixels for a hit.
- `COOLDOWN_FRAMES`, 20 — frames before a fighter may launch again.
- `STUN_FRAMES`, 12 — frames a hit, unblocked defender cannot launch.

Ports:
- `Clk` in 1 — the single clock (25 MHz pixel clock).
- `reset_rtl_0` in 1 — asynchronous, active-low reset.
- `vsync` in 1 — raw VGA vsync, asynchronous to this block's logic.
- `fighting` in 1 — high while `states` is in the fight screen.
- `punchL`, `kickL`, `blockL` in 1 each — left fighter action flags.
- `punchR`, `kickR`, `blockR` in 1 each — right fighter action flags.
- `edgeL_R` in 10 — right edge X of the left fighter.
- `edgeR_L` in 10 — left edge X of the right fighter.
- `healthL`, `healthR` out 8 — current health.
- `deathL`, `deathR` out 1 — latched KO flags.
- `stunL`, `stunR` out 1 — high while the stun counter is nonzero.
- `hit_pulse` out 2 — one-cycle pulse; bit0 = left hit right, bit1 = right hit left.

## Operation
- Frame tick: `vsync` passes through a 2-flop synchronizer, then rising-edge detect; the tick is one `Clk` wide.
- FSM states: IDLE, FIGHT, RESOLVE, KO.
  - IDLE: health held at HEALTH_MAX, all counters 0, death 0. `fighting`=1 → FIGHT.
  - FIGHT: on tick → RESOLVE.
  - RESOLVE: one cycle; computes and commits all updates. Any health reaching 0 → KO, else → FIGHT.
  - KO: outputs frozen, ticks ignored.
  - From any non-IDLE state, `fighting`=0 → IDLE, taking priority over a tick in the same cycle.
- Launch per fighter, evaluated in RESOLVE:
  - Requires an attack flag rising edge, i.e. (punch|kick) now and not at the previous tick; the previous-sample register updates every tick.
  - Also requires cooldown==0 and stun==0.
  - Kick wins over punch when both are set.
  - A launch loads cooldown=COOLDOWN_FRAMES whether it hits or misses.
- Range: gap = {1'b0,`edgeR_L`} − {1'b0,`edgeL_R`}, 11-bit signed. Hit if gap ≤ REACH; overlap (negative gap) counts as in range.
- Damage to the defender:
  - Defender block=1 → dmg >> BLOCK_SHIFT; no stun applied.
  - Defender block=0 → full dmg; defender stun loaded with STUN_FRAMES.
  - Health saturates at 0; no underflow.
- Simultaneous launches: both resolve against pre-RESOLVE state (trade). Both reaching 0 in the same RESOLVE → `deathL`=`deathR`=1 (draw).
- Counters: cooldown and stun decrement by 1 per tick in RESOLVE before launch evaluation, saturating at 0. A stun counter that reaches 0 in this RESOLVE allows a launch in the same RESOLVE.
- `hit_pulse` bits assert in the cycle after RESOLVE, only for landed hits.

## Timing
- Reset values:
  - state IDLE; `healthL`=`healthR`=HEALTH_MAX.
  - `deathL`=`deathR`=0, `stunL`=`stunR`=0, `hit_pulse`=0, all counters and edge registers 0.
- Latency: `vsync` rising → tick 3 `Clk` later → RESOLVE the next cycle. Health, death, stun and `hit_pulse` update on the following edge, 5 `Clk` after `vsync` rises.
- Inputs other than `vsync` are quasi-static per frame; they are sampled only in RESOLVE.
- Reset mid-RESOLVE: all registers return to reset values immediately (asynchronous); no partial update survives.

## Structure
- `combat_pkg` holds:
  - the state enum (IDLE/FIGHT/RESOLVE/KO);
  - the attack-kind enum (NONE/PUNCH/KICK);
  - the default damage constants;
  - the function `dmg_of(kind, blocked)`.
- Sub-module `fighter_timer` (cooldown + stun counters, `ready` output), instantiated once per fighter.

## Test plan
- Reset, then `fighting`=1 → health 100/100, FSM in FIGHT; no change without attack edges over 10 frames.
- Left kick rise, gap=10, right not blocking → `healthR`=90, `stunR`=1 for 12 frames, `hit_pulse`=01 at 5 cycles after `vsync`.
- Same as above with `blockR`=1 → `healthR`=98 (10>>2), `stunR` stays 0; a second kick 5 frames later is ignored (cooldown); at frame 20 a new edge lands.
- Both punch in the same frame at gap=0 → 95/95, `hit_pulse`=11. Gap=17 → no damage, but both cooldowns still loaded.
- Health 5/5, both punch in the same frame → 0/0, `deathL`=`deathR`=1, KO; further attacks change nothing; `fighting`=0 → IDLE, health 100.
- Assert reset during RESOLVE → all outputs at reset values on the same cycle.
